// File: rtl/dmac_list_tbl.sv
// dmac_list_tbl
//   Hash-indexed destination-MAC table. There is one entry per hash index,
//   holding {valid, mac, port, age}. The block answers lookup and learn
//   requests from the lookup manager, and flags a clash when an index is
//   already held by a different MAC. A background aging sweep ages every
//   entry and reports the ones that expire.
//
// Ports
//   i_clk, i_rst                    clock; asynchronous active-low reset
//   i_tbl_clr                       pulse: invalidate every entry
//   i_age_tick                      pulse: start one aging sweep
//   i_local_mac                     MAC of the local NIC
//   i_dmac_item_mac_addr/_vld/_we   request index, valid, 1=learn 0=lookup
//   i_dmac_item_mac_in/_rx_port     MAC and one-hot port of the request
//   o_dmac_rdy                      request accepted when vld & rdy
//   o_dmac_tx_port_rslt/_vld        lookup result (MSB = local NIC) and pulse
//   o_clash_out                     lookup hit an entry owned by another MAC
//   o_learn_clash                   learn refused: entry owned by another MAC
//   o_dmac_old_en/_num              entry aged out, and its index
module dmac_list_tbl #(
  parameter int HASH_DATA_WIDTH = 12,
  parameter int PORT_NUM        = 4,
  parameter int AGE_WIDTH       = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_tbl_clr,
  input  logic                       i_age_tick,
  input  logic [47:0]                i_local_mac,
  input  logic [HASH_DATA_WIDTH-1:0] i_dmac_item_mac_addr,
  input  logic                       i_dmac_item_mac_addr_vld,
  input  logic                       i_dmac_item_mac_we,
  input  logic [47:0]                i_dmac_item_mac_in,
  input  logic [PORT_NUM-1:0]        i_dmac_item_mac_rx_port,
  output logic                       o_dmac_rdy,
  output logic [PORT_NUM:0]          o_dmac_tx_port_rslt,
  output logic                       o_dmac_tx_port_vld,
  output logic                       o_clash_out,
  output logic                       o_learn_clash,
  output logic                       o_dmac_old_en,
  output logic [HASH_DATA_WIDTH-1:0] o_dmac_old_num
);

  localparam int DEPTH   = 1 << HASH_DATA_WIDTH;
  localparam int ENTRY_W = 1 + 48 + PORT_NUM + AGE_WIDTH;
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;
  localparam logic [AGE_WIDTH-1:0] AGE_ONE = {{(AGE_WIDTH-1){1'b0}}, 1'b1};

  localparam logic [2:0] S_CLR    = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_AGE_RD = 3'd3;
  localparam logic [2:0] S_AGE_WR = 3'd4;

  logic [2:0]                 r_state;
  logic [HASH_DATA_WIDTH-1:0] r_clr_ptr;
  logic [HASH_DATA_WIDTH-1:0] r_age_ptr;
  logic                       r_clr_pend;
  logic                       r_sweep_pend;
  logic                       r_req_we;
  logic [HASH_DATA_WIDTH-1:0] r_req_addr;
  logic [47:0]                r_req_mac;
  logic [PORT_NUM-1:0]        r_req_port;
  logic [PORT_NUM:0]          r_rslt;
  logic                       r_vld;
  logic                       r_clash;
  logic                       r_lclash;
  logic                       r_old_en;
  logic [HASH_DATA_WIDTH-1:0] r_old_num;

  logic [ENTRY_W-1:0]         r_mem [DEPTH];
  logic [ENTRY_W-1:0]         r_rd_data;

  logic [HASH_DATA_WIDTH-1:0] w_ram_addr;
  logic                       w_ram_we;
  logic [ENTRY_W-1:0]         w_ram_wdata;

  // Fields of the entry read in the previous cycle
  logic                       w_rd_valid;
  logic [47:0]                w_rd_mac;
  logic [PORT_NUM-1:0]        w_rd_port;
  logic [AGE_WIDTH-1:0]       w_rd_age;
  logic [AGE_WIDTH-1:0]       w_age_dec;
  logic                       w_mac_hit;

  assign w_rd_valid = r_rd_data[ENTRY_W-1];
  assign w_rd_mac   = r_rd_data[ENTRY_W-2 -: 48];
  assign w_rd_port  = r_rd_data[PORT_NUM+AGE_WIDTH-1 -: PORT_NUM];
  assign w_rd_age   = r_rd_data[AGE_WIDTH-1:0];
  assign w_age_dec  = w_rd_age - AGE_ONE;
  assign w_mac_hit  = w_rd_valid && (w_rd_mac == r_req_mac);

  assign o_dmac_rdy          = (r_state == S_IDLE) && !r_clr_pend;
  assign o_dmac_tx_port_rslt = r_rslt;
  assign o_dmac_tx_port_vld  = r_vld;
  assign o_clash_out         = r_clash;
  assign o_learn_clash       = r_lclash;
  assign o_dmac_old_en       = r_old_en;
  assign o_dmac_old_num      = r_old_num;

  // Single RAM port shared by clear, request and aging. In S_IDLE the
  // request index addresses the RAM directly, so the entry is available
  // in S_REQ, one cycle after acceptance.
  always_comb begin
    w_ram_addr  = r_age_ptr;
    w_ram_we    = 1'b0;
    w_ram_wdata = '0;
    case (r_state)
      S_CLR: begin
        w_ram_addr = r_clr_ptr;
        w_ram_we   = 1'b1;
      end
      S_IDLE: w_ram_addr = i_dmac_item_mac_addr;
      S_REQ: begin
        w_ram_addr  = r_req_addr;
        w_ram_we    = r_req_we && (!w_rd_valid || w_mac_hit);
        w_ram_wdata = {1'b1, r_req_mac, r_req_port, AGE_MAX};
      end
      S_AGE_WR: begin
        w_ram_we = w_rd_valid;
        if (w_rd_age == '0)
          w_ram_wdata = {1'b0, w_rd_mac, w_rd_port, w_rd_age};
        else
          w_ram_wdata = {1'b1, w_rd_mac, w_rd_port, w_age_dec};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_ram_we)
      r_mem[w_ram_addr] <= w_ram_wdata;
    r_rd_data <= r_mem[w_ram_addr];
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= S_CLR;
      r_clr_ptr    <= '0;
      r_age_ptr    <= '0;
      r_clr_pend   <= 1'b0;
      r_sweep_pend <= 1'b0;
      r_req_we     <= 1'b0;
      r_req_addr   <= '0;
      r_req_mac    <= '0;
      r_req_port   <= '0;
      r_rslt       <= '0;
      r_vld        <= 1'b0;
      r_clash      <= 1'b0;
      r_lclash     <= 1'b0;
      r_old_en     <= 1'b0;
      r_old_num    <= '0;
    end else begin
      r_vld    <= 1'b0;
      r_clash  <= 1'b0;
      r_lclash <= 1'b0;
      r_old_en <= 1'b0;
      case (r_state)
        S_CLR: begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (r_clr_ptr == '1)
            r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (r_clr_pend) begin
            // A clear restarts the table, so any running sweep is moot
            r_clr_pend   <= 1'b0;
            r_clr_ptr    <= '0;
            r_age_ptr    <= '0;
            r_sweep_pend <= 1'b0;
            r_state      <= S_CLR;
          end else if (i_dmac_item_mac_addr_vld) begin
            r_req_we   <= i_dmac_item_mac_we;
            r_req_addr <= i_dmac_item_mac_addr;
            r_req_mac  <= i_dmac_item_mac_in;
            r_req_port <= i_dmac_item_mac_rx_port;
            r_state    <= S_REQ;
          end else if (r_sweep_pend) begin
            r_state <= S_AGE_RD;
          end
        end
        S_REQ: begin
          if (!r_req_we) begin
            if (r_req_mac == i_local_mac) begin
              r_rslt <= {1'b1, {PORT_NUM{1'b0}}};
              r_vld  <= 1'b1;
            end else if (w_mac_hit) begin
              r_rslt <= {1'b0, w_rd_port};
              r_vld  <= 1'b1;
            end else if (!w_rd_valid) begin
              r_rslt <= {1'b0, {PORT_NUM{1'b1}}};
              r_vld  <= 1'b1;
            end else begin
              r_clash <= 1'b1;
            end
          end else if (w_rd_valid && !w_mac_hit) begin
            r_lclash <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        S_AGE_RD: r_state <= S_AGE_WR;
        S_AGE_WR: begin
          if (w_rd_valid && (w_rd_age == '0)) begin
            r_old_en  <= 1'b1;
            r_old_num <= r_age_ptr;
          end
          r_age_ptr <= r_age_ptr + 1'b1;
          if (r_age_ptr == '1)
            r_sweep_pend <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // New pulses are latched last so they are never lost to a same-cycle
      // take or wrap.
      if (i_tbl_clr)
        r_clr_pend <= 1'b1;
      if (i_age_tick)
        r_sweep_pend <= 1'b1;
    end
  end

endmodule
